// File: rtl/hazard_scoreboard_unit.sv
// Pipeline hazard unit with a per-register scoreboard for multi-cycle units.
// Drives F->D, D->E, E->M, M->W enables/flushes, a sticky halt and a decode-stall counter.
module hazard_scoreboard_unit #(
    parameter int unsigned NREGS  = 32,
    parameter int unsigned REG_W  = 5,
    parameter int unsigned NUNITS = 2,
    parameter int unsigned CNT_W  = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              halt,
    input  logic              ihit,
    input  logic              dhit,
    input  logic              dread,
    input  logic              dwrite,
    input  logic              branch_flush,
    input  logic              dec_valid,
    input  logic [REG_W-1:0]  dec_rs1,
    input  logic [REG_W-1:0]  dec_rs2,
    input  logic [REG_W-1:0]  dec_rd,
    input  logic              dec_rd_we,
    input  logic [NUNITS-1:0] dec_long,
    input  logic              dec_csr,
    input  logic [NUNITS-1:0] unit_busy,
    input  logic              ex_csr,
    input  logic              mem_csr,
    input  logic              wb_csr,
    input  logic              wb_valid,
    input  logic [REG_W-1:0]  wb_rd,
    output logic              f2d_en,
    output logic              d2e_en,
    output logic              e2m_en,
    output logic              m2w_en,
    output logic              f2d_flush,
    output logic              d2e_flush,
    output logic              e2m_flush,
    output logic              m2w_flush,
    output logic              halted,
    output logic [NREGS-1:0]  pending,
    output logic [CNT_W-1:0]  stall_cycles
);

    typedef enum logic {
        S_RUN,
        S_HALT
    } run_state_t;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_FREEZE,
        SEL_HOLD,
        SEL_BRANCH,
        SEL_DSTALL,
        SEL_IMISS
    } ctl_sel_t;

    run_state_t       state_q, state_d;
    ctl_sel_t         sel;
    logic [NREGS-1:0] pending_nxt;
    logic             mem_stall;
    logic             raw, waw, strct, csr, dstall;
    logic             sb_set, sb_clr;

    // Hazard terms
    always_comb begin
        mem_stall = (dread | dwrite) & ~dhit;
        raw       = dec_valid & (((dec_rs1 != '0) & pending[dec_rs1]) |
                                 ((dec_rs2 != '0) & pending[dec_rs2]));
        waw       = dec_valid & dec_rd_we & (dec_rd != '0) & pending[dec_rd];
        strct     = dec_valid & (|(dec_long & unit_busy));
        csr       = dec_valid & dec_csr & (ex_csr | mem_csr | wb_csr);
        dstall    = raw | waw | strct | csr;
    end

    assign halted = (state_q == S_HALT);

    // Priority selection, first match wins
    always_comb begin
        sel = SEL_NONE;
        if (halted)            sel = SEL_FREEZE;
        else if (mem_stall)    sel = SEL_HOLD;
        else if (branch_flush) sel = SEL_BRANCH;
        else if (dstall)       sel = SEL_DSTALL;
        else if (!ihit)        sel = SEL_IMISS;
    end

    always_comb begin
        f2d_en    = 1'b1;
        d2e_en    = 1'b1;
        e2m_en    = 1'b1;
        m2w_en    = 1'b1;
        f2d_flush = 1'b0;
        d2e_flush = 1'b0;
        e2m_flush = 1'b0;
        m2w_flush = 1'b0;
        if (RST) begin
            f2d_en    = 1'b0;
            d2e_en    = 1'b0;
            e2m_en    = 1'b0;
            m2w_en    = 1'b0;
            f2d_flush = 1'b1;
            d2e_flush = 1'b1;
            e2m_flush = 1'b1;
            m2w_flush = 1'b1;
        end else begin
            unique case (sel)
                SEL_FREEZE, SEL_HOLD: begin
                    f2d_en = 1'b0;
                    d2e_en = 1'b0;
                    e2m_en = 1'b0;
                    m2w_en = 1'b0;
                end
                SEL_BRANCH: begin
                    f2d_flush = 1'b1;
                    d2e_flush = 1'b1;
                end
                SEL_DSTALL: begin
                    f2d_en    = 1'b0;
                    d2e_flush = 1'b1;
                end
                SEL_IMISS: f2d_flush = 1'b1;
                default: ;
            endcase
        end
    end

    // Only an instruction actually moving into EX claims its destination
    always_comb begin
        sb_set      = d2e_en & ~d2e_flush & dec_valid & dec_rd_we &
                      (|dec_long) & (dec_rd != '0);
        sb_clr      = wb_valid & (wb_rd != '0);
        pending_nxt = pending;
        if (sb_clr) pending_nxt[wb_rd]  = 1'b0;
        if (sb_set) pending_nxt[dec_rd] = 1'b1;
        pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge CLK) begin
        if (RST) pending <= '0;
        else     pending <= pending_nxt;
    end

    always_comb begin
        state_d = state_q;
        if (state_q == S_RUN && halt && !mem_stall) state_d = S_HALT;
    end

    always_ff @(posedge CLK) begin
        if (RST) state_q <= S_RUN;
        else     state_q <= state_d;
    end

    always_ff @(posedge CLK) begin
        if (RST)
            stall_cycles <= '0;
        else if (sel == SEL_DSTALL && stall_cycles != '1)
            stall_cycles <= stall_cycles + CNT_W'(1);
    end

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Bench for hazard_scoreboard_unit: directed scenarios plus a randomized run
// against a behavioural scoreboard model.
module tb_hazard_scoreboard_unit;

    localparam int NREGS  = 32;
    localparam int REG_W  = 5;
    localparam int NUNITS = 2;
    localparam int CNT_W  = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic CLK, RST, halt, ihit, dhit, dread, dwrite, branch_flush, dec_valid;
    logic [REG_W-1:0] dec_rs1, dec_rs2, dec_rd, wb_rd;
    logic dec_rd_we, dec_csr, ex_csr, mem_csr, wb_csr, wb_valid;
    logic [NUNITS-1:0] dec_long, unit_busy;
    logic f2d_en, d2e_en, e2m_en, m2w_en, f2d_flush, d2e_flush, e2m_flush, m2w_flush;
    logic halted;
    logic [NREGS-1:0] pending;
    logic [CNT_W-1:0] stall_cycles;
    logic [7:0] ctl;

    hazard_scoreboard_unit #(.NREGS(NREGS), .REG_W(REG_W), .NUNITS(NUNITS), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .RST(RST), .halt(halt), .ihit(ihit), .dhit(dhit), .dread(dread),
        .dwrite(dwrite), .branch_flush(branch_flush), .dec_valid(dec_valid),
        .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd), .dec_rd_we(dec_rd_we),
        .dec_long(dec_long), .dec_csr(dec_csr), .unit_busy(unit_busy), .ex_csr(ex_csr),
        .mem_csr(mem_csr), .wb_csr(wb_csr), .wb_valid(wb_valid), .wb_rd(wb_rd),
        .f2d_en(f2d_en), .d2e_en(d2e_en), .e2m_en(e2m_en), .m2w_en(m2w_en),
        .f2d_flush(f2d_flush), .d2e_flush(d2e_flush), .e2m_flush(e2m_flush),
        .m2w_flush(m2w_flush), .halted(halted), .pending(pending), .stall_cycles(stall_cycles)
    );

    assign ctl = {f2d_en, d2e_en, e2m_en, m2w_en, f2d_flush, d2e_flush, e2m_flush, m2w_flush};

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int tests_run = 0;
    int failures  = 0;

    // Reference state
    bit mp [NREGS];
    bit m_halted;
    int m_cnt;

    function automatic bit m_memstall();
        return (dread || dwrite) && !dhit;
    endfunction

    function automatic bit m_dstall();
        bit r, w, s, c;
        r = dec_valid && ((dec_rs1 != 0 && mp[dec_rs1]) || (dec_rs2 != 0 && mp[dec_rs2]));
        w = dec_valid && dec_rd_we && dec_rd != 0 && mp[dec_rd];
        s = dec_valid && ((dec_long & unit_busy) != 0);
        c = dec_valid && dec_csr && (ex_csr || mem_csr || wb_csr);
        return r || w || s || c;
    endfunction

    // {en f2d,d2e,e2m,m2w, flush f2d,d2e,e2m,m2w}
    function automatic logic [7:0] model_ctl();
        if (RST)               return 8'b0000_1111;
        if (m_halted)          return 8'b0000_0000;
        if (m_memstall())      return 8'b0000_0000;
        if (branch_flush)      return 8'b1111_1100;
        if (m_dstall())        return 8'b0111_0100;
        if (!ihit)             return 8'b1111_1000;
        return 8'b1111_0000;
    endfunction

    function automatic logic [NREGS-1:0] model_pend();
        logic [NREGS-1:0] v;
        for (int i = 0; i < NREGS; i++) v[i] = mp[i];
        return v;
    endfunction

    // Advance one clock and the model with the inputs that were present at the edge
    task automatic tick();
        logic [7:0] c;
        bit ms, ds, issue;
        @(posedge CLK);
        c  = model_ctl();
        ms = m_memstall();
        ds = !m_halted && !ms && !branch_flush && m_dstall();
        if (RST) begin
            for (int i = 0; i < NREGS; i++) mp[i] = 0;
            m_halted = 0;
            m_cnt    = 0;
        end else begin
            issue = c[6] && !c[2] && dec_valid && dec_rd_we && dec_long != 0 && dec_rd != 0;
            if (wb_valid && wb_rd != 0) mp[wb_rd] = 0;
            if (issue) mp[dec_rd] = 1;
            if (halt && !ms) m_halted = 1;
            if (ds && m_cnt < CNT_MAX) m_cnt++;
        end
        #1;
    endtask

    task automatic set_idle();
        halt = 0; ihit = 1; dhit = 1; dread = 0; dwrite = 0; branch_flush = 0;
        dec_valid = 0; dec_rs1 = 0; dec_rs2 = 0; dec_rd = 0; dec_rd_we = 0;
        dec_long = 0; dec_csr = 0; unit_busy = 0; ex_csr = 0; mem_csr = 0; wb_csr = 0;
        wb_valid = 0; wb_rd = 0;
    endtask

    task automatic do_reset();
        set_idle();
        RST = 1;
        tick();
        tick();
        RST = 0;
    endtask

    task automatic issue_long(input logic [REG_W-1:0] rd, input logic [NUNITS-1:0] u);
        dec_valid = 1; dec_rd = rd; dec_rd_we = 1; dec_long = u; dec_rs1 = 0; dec_rs2 = 0;
    endtask

    task automatic test_reset();
        set_idle();
        RST = 1;
        for (int i = 0; i < 2; i++) begin
            #1;
            tests_run++;
            if (ctl !== 8'b0000_1111) begin
                failures++; $display("FAIL reset_ctl got %b exp %b", ctl, 8'b0000_1111);
            end
            tick();
        end
        RST = 0;
        tests_run++;
        if (pending !== '0 || stall_cycles !== '0 || halted !== 1'b0) begin
            failures++;
            $display("FAIL reset_state pend=%h cnt=%0d halted=%b exp 0/0/0", pending, stall_cycles, halted);
        end
        #1;
        tests_run++;
        if (ctl !== 8'b1111_0000) begin
            failures++; $display("FAIL reset_release_ctl got %b exp %b", ctl, 8'b1111_0000);
        end
    endtask

    task automatic test_load_use();
        do_reset();
        issue_long(5'd5, 2'b01);
        #1;
        tick();
        tests_run++;
        if (pending !== 32'h0000_0020) begin
            failures++; $display("FAIL load_set pend got %h exp %h", pending, 32'h20);
        end
        dec_long = 0; dec_rd = 6; dec_rs1 = 5;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) begin wb_valid = 1; wb_rd = 5; end
            #1;
            tests_run++;
            if (ctl !== 8'b0111_0100) begin
                failures++; $display("FAIL load_stall[%0d] ctl got %b exp %b", i, ctl, 8'b0111_0100);
            end
            tick();
        end
        wb_valid = 0;
        #1;
        tests_run++;
        if (ctl !== 8'b1111_0000 || pending !== '0) begin
            failures++; $display("FAIL load_release ctl=%b pend=%h exp 11110000/0", ctl, pending);
        end
        tests_run++;
        if (stall_cycles !== CNT_W'(4)) begin
            failures++; $display("FAIL load_stall_count got %0d exp 4", stall_cycles);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        do_reset();
        issue_long(5'd9, 2'b10);
        wb_valid = 1; wb_rd = 9;
        #1;
        tick();
        tests_run++;
        if (pending !== 32'h0000_0200) begin
            failures++; $display("FAIL set_wins pend got %h exp %h", pending, 32'h200);
        end
        set_idle();
        wb_valid = 1; wb_rd = 0;
        tick();
        tests_run++;
        if (pending !== 32'h0000_0200) begin
            failures++; $display("FAIL wb_r0 pend got %h exp %h", pending, 32'h200);
        end
    endtask

    task automatic test_structural();
        do_reset();
        dec_valid = 1; dec_long = 2'b10; unit_busy = 2'b10;
        for (int i = 0; i < 3; i++) begin
            #1;
            tests_run++;
            if (ctl !== 8'b0111_0100) begin
                failures++; $display("FAIL struct_bubble[%0d] ctl got %b exp %b", i, ctl, 8'b0111_0100);
            end
            tick();
        end
        dec_long = 2'b01;
        #1;
        tests_run++;
        if (ctl !== 8'b1111_0000 || stall_cycles !== CNT_W'(3)) begin
            failures++; $display("FAIL struct_unit0 ctl=%b cnt=%0d exp 11110000/3", ctl, stall_cycles);
        end
        tick();
    endtask

    task automatic test_memstall_branch();
        do_reset();
        dread = 1; dhit = 0; branch_flush = 1;
        #1;
        tests_run++;
        if (ctl !== 8'b0000_0000) begin
            failures++; $display("FAIL memstall_hold ctl got %b exp %b", ctl, 8'b0);
        end
        tick();
        dhit = 1;
        #1;
        tests_run++;
        if (ctl !== 8'b1111_1100) begin
            failures++; $display("FAIL branch_after_hit ctl got %b exp %b", ctl, 8'b1111_1100);
        end
        tick();
        set_idle();
        ihit = 0;
        #1;
        tests_run++;
        if (ctl !== 8'b1111_1000) begin
            failures++; $display("FAIL imiss ctl got %b exp %b", ctl, 8'b1111_1000);
        end
        tick();
    endtask

    task automatic test_squash();
        do_reset();
        issue_long(5'd7, 2'b01);
        branch_flush = 1;
        tick();
        tests_run++;
        if (pending !== '0) begin
            failures++; $display("FAIL squash_no_set pend got %h exp 0", pending);
        end
        branch_flush = 0;
        issue_long(5'd0, 2'b10);
        tick();
        tests_run++;
        if (pending !== '0) begin
            failures++; $display("FAIL rd0_no_set pend got %h exp 0", pending);
        end
    endtask

    task automatic test_csr_halt();
        do_reset();
        dec_valid = 1; dec_csr = 1; mem_csr = 1;
        #1;
        tests_run++;
        if (ctl !== 8'b0111_0100) begin
            failures++; $display("FAIL csr_stall ctl got %b exp %b", ctl, 8'b0111_0100);
        end
        set_idle();
        halt = 1; dread = 1; dhit = 0;
        tick();
        tests_run++;
        if (halted !== 1'b0) begin
            failures++; $display("FAIL halt_blocked_by_memstall got %b exp 0", halted);
        end
        dhit = 1;
        tick();
        halt = 0;
        tests_run++;
        if (halted !== 1'b1) begin
            failures++; $display("FAIL halt_set got %b exp 1", halted);
        end
        branch_flush = 1; ihit = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            tests_run++;
            if (ctl !== 8'b0000_0000 || halted !== 1'b1) begin
                failures++; $display("FAIL halt_freeze[%0d] ctl=%b halted=%b exp 0/1", i, ctl, halted);
            end
            tick();
        end
        do_reset();
        tests_run++;
        if (halted !== 1'b0) begin
            failures++; $display("FAIL halt_cleared_by_rst got %b exp 0", halted);
        end
    endtask

    task automatic test_saturate();
        do_reset();
        issue_long(5'd3, 2'b01);
        tick();
        dec_long = 0; dec_rd = 0; dec_rd_we = 0; dec_rs2 = 3;
        for (int i = 0; i < CNT_MAX + 5; i++) tick();
        tests_run++;
        if (stall_cycles !== CNT_W'(CNT_MAX)) begin
            failures++; $display("FAIL stall_saturate got %0d exp %0d", stall_cycles, CNT_MAX);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            RST          = ($urandom_range(0, 59) == 0);
            halt         = ($urandom_range(0, 99) == 0);
            ihit         = ($urandom_range(0, 7) != 0);
            dhit         = ($urandom_range(0, 3) != 0);
            dread        = ($urandom_range(0, 3) == 0);
            dwrite       = ($urandom_range(0, 5) == 0);
            branch_flush = ($urandom_range(0, 7) == 0);
            dec_valid    = ($urandom_range(0, 4) != 0);
            dec_rs1      = REG_W'($urandom_range(0, 7));
            dec_rs2      = REG_W'($urandom_range(0, 7));
            dec_rd       = REG_W'($urandom_range(0, 7));
            dec_rd_we    = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 2))
                0: dec_long = 2'b00;
                1: dec_long = 2'b01;
                default: dec_long = 2'b10;
            endcase
            dec_csr      = ($urandom_range(0, 7) == 0);
            unit_busy    = NUNITS'($urandom_range(0, 3));
            ex_csr       = ($urandom_range(0, 3) == 0);
            mem_csr      = ($urandom_range(0, 3) == 0);
            wb_csr       = ($urandom_range(0, 3) == 0);
            wb_valid     = ($urandom_range(0, 2) == 0);
            wb_rd        = REG_W'($urandom_range(0, 7));
            #1;
            tests_run++;
            if (ctl !== model_ctl()) begin
                failures++; $display("FAIL rand_ctl[%0d] got %b exp %b", i, ctl, model_ctl());
            end
            tick();
            tests_run++;
            if (pending !== model_pend() || halted !== m_halted || stall_cycles !== CNT_W'(m_cnt)) begin
                failures++;
                $display("FAIL rand_state[%0d] pend=%h/%h halted=%b/%b cnt=%0d/%0d (got/exp)",
                         i, pending, model_pend(), halted, m_halted, stall_cycles, m_cnt);
            end
        end
        RST = 0;
    endtask

    initial begin
        RST = 1;
        set_idle();
        test_reset();
        test_load_use();
        test_back_to_back();
        test_structural();
        test_memstall_branch();
        test_squash();
        test_csr_halt();
        test_saturate();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule
